// File: rtl/pid_pkg.sv
// Shared types and constants for the PID output path and its DAC writer.
package pid_pkg;

    localparam int DAC_W       = 12;
    localparam int DAC_FRAME_W = 16;
    localparam logic [DAC_FRAME_W-1:0] UMAX = 16'h0FFF;
    localparam logic [3:0] CFG_BITS_DEF = 4'b0011;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        LDAC,
        DONE
    } dac_state_t;

    function automatic logic [DAC_FRAME_W-1:0] dac_frame(input logic [3:0] cfg,
                                                         input logic [DAC_W-1:0] code);
        return {cfg, code};
    endfunction

endpackage

// File: rtl/dac_spi_writer_sclk_tick_gen.sv
// SCLK half-period tick generator; held at zero whenever not enabled or cleared.
module sclk_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dac_spi_writer.sv
// Writes the saturated 12-bit control word to an MCP4921-style SPI DAC (mode 0),
// then strobes LDAC_n and pulses o_done.
module dac_spi_writer
    import pid_pkg::*;
#(
    parameter int         CLK_DIV  = 4,
    parameter logic [3:0] CFG_BITS = CFG_BITS_DEF,
    parameter int         LDAC_CYC = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_start,
    input  logic [DAC_FRAME_W-1:0] i_data,
    output logic                   o_sclk,
    output logic                   o_mosi,
    output logic                   o_cs_n,
    output logic                   o_ldac_n,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int LW = (LDAC_CYC > 1) ? $clog2(LDAC_CYC) : 1;

    dac_state_t             state;
    logic [DAC_FRAME_W-1:0] shift_reg;
    logic [3:0]             bit_cnt;
    logic [LW-1:0]          ldac_cnt;
    logic                   pend_valid;
    logic [DAC_W-1:0]       pend_data;
    logic                   tick;
    logic                   tick_en;
    logic [DAC_FRAME_W-1:0] load_frame;
    logic                   unused_data_hi;

    assign unused_data_hi = ^i_data[DAC_FRAME_W-1:DAC_W];
    assign tick_en = (state == CS_SETUP) || (state == SHIFT) || (state == CS_HOLD);

    // A start landing in DONE goes straight into the next frame rather than
    // through the pending register, so it cannot be lost on the restart edge.
    always_comb begin
        load_frame = dac_frame(CFG_BITS, i_data[DAC_W-1:0]);
        if (state == DONE && !i_start) begin
            load_frame = dac_frame(CFG_BITS, pend_data);
        end
    end

    sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (tick_en),
        .clear (!tick_en),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            ldac_cnt   <= '0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
            o_sclk     <= 1'b0;
            o_mosi     <= 1'b0;
            o_cs_n     <= 1'b1;
            o_ldac_n   <= 1'b1;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_start && state != IDLE && state != DONE) begin
                pend_data  <= i_data[DAC_W-1:0];
                pend_valid <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state     <= CS_SETUP;
                        shift_reg <= load_frame;
                        o_mosi    <= load_frame[DAC_FRAME_W-1];
                        o_cs_n    <= 1'b0;
                        o_busy    <= 1'b1;
                        bit_cnt   <= '0;
                    end
                end
                CS_SETUP: begin
                    if (tick) state <= SHIFT;
                end
                SHIFT: begin
                    if (tick) begin
                        if (!o_sclk) begin
                            o_sclk <= 1'b1;
                        end else begin
                            o_sclk <= 1'b0;
                            if (bit_cnt == 4'd15) begin
                                state   <= CS_HOLD;
                                o_mosi  <= 1'b0;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt   <= bit_cnt + 1'b1;
                                o_mosi    <= shift_reg[DAC_FRAME_W-2];
                                shift_reg <= {shift_reg[DAC_FRAME_W-2:0], 1'b0};
                            end
                        end
                    end
                end
                CS_HOLD: begin
                    if (tick) begin
                        state    <= LDAC;
                        o_cs_n   <= 1'b1;
                        o_ldac_n <= 1'b0;
                        ldac_cnt <= '0;
                    end
                end
                LDAC: begin
                    if (ldac_cnt == LW'(LDAC_CYC - 1)) begin
                        state    <= DONE;
                        o_ldac_n <= 1'b1;
                        o_done   <= 1'b1;
                    end else begin
                        ldac_cnt <= ldac_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (i_start || pend_valid) begin
                        state      <= CS_SETUP;
                        shift_reg  <= load_frame;
                        o_mosi     <= load_frame[DAC_FRAME_W-1];
                        o_cs_n     <= 1'b0;
                        bit_cnt    <= '0;
                        pend_valid <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_writer.sv
// Directed bench: default-parameter writer plus a CLK_DIV=1/LDAC_CYC=1 instance.
module tb_dac_spi_writer;

    logic        clk;
    logic        reset;
    logic        start0, start1;
    logic [15:0] data0, data1;
    logic        sclk0, mosi0, cs0, ldac0, busy0, done0;
    logic        sclk1, mosi1, cs1, ldac1, busy1, done1;

    int n_vec = 0;
    int n_err = 0;
    int ncyc  = 0;

    dac_spi_writer dut0 (
        .clk(clk), .reset(reset), .i_start(start0), .i_data(data0),
        .o_sclk(sclk0), .o_mosi(mosi0), .o_cs_n(cs0), .o_ldac_n(ldac0),
        .o_busy(busy0), .o_done(done0)
    );

    dac_spi_writer #(.CLK_DIV(1), .LDAC_CYC(1)) dut1 (
        .clk(clk), .reset(reset), .i_start(start1), .i_data(data1),
        .o_sclk(sclk1), .o_mosi(mosi1), .o_cs_n(cs1), .o_ldac_n(ldac1),
        .o_busy(busy1), .o_done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) ncyc <= ncyc + 1;

    logic sclk_a[2], mosi_a[2], cs_a[2], ldac_a[2], done_a[2];
    always_comb begin
        sclk_a[0] = sclk0; mosi_a[0] = mosi0; cs_a[0] = cs0; ldac_a[0] = ldac0; done_a[0] = done0;
        sclk_a[1] = sclk1; mosi_a[1] = mosi1; cs_a[1] = cs1; ldac_a[1] = ldac1; done_a[1] = done1;
    end

    // Per-DUT bus monitor: captured frames, DONE cycles and LDAC pulses.
    logic [15:0] frm[2][32];
    int fbits[2][32], fcs[2][32], fspan[2][32], frise[2][32];
    int dcyc[2][32], lfirst[2][32], llen[2][32];
    int nfrm[2] = '{0, 0};
    int ndone[2] = '{0, 0};
    int nldac[2] = '{0, 0};
    logic [15:0] sh[2];
    int nb[2], csl[2], rf[2], rl[2], lf[2], ll[2];
    logic pcs[2], psclk[2], pldac[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                pcs[i] = 1'b1; psclk[i] = 1'b0; pldac[i] = 1'b1; nb[i] = 0;
            end else begin
                if (pcs[i] && !cs_a[i]) begin nb[i] = 0; csl[i] = 0; end
                if (!cs_a[i]) csl[i]++;
                if (!psclk[i] && sclk_a[i]) begin
                    sh[i] = {sh[i][14:0], mosi_a[i]};
                    if (nb[i] == 0) rf[i] = ncyc;
                    rl[i] = ncyc;
                    nb[i]++;
                end
                if (!pcs[i] && cs_a[i] && nfrm[i] < 32) begin
                    frm[i][nfrm[i]] = sh[i]; fbits[i][nfrm[i]] = nb[i];
                    fcs[i][nfrm[i]] = csl[i]; fspan[i][nfrm[i]] = rl[i] - rf[i];
                    frise[i][nfrm[i]] = rf[i];
                    nfrm[i]++;
                end
                if (pldac[i] && !ldac_a[i]) begin lf[i] = ncyc; ll[i] = 0; end
                if (!ldac_a[i]) ll[i]++;
                if (!pldac[i] && ldac_a[i] && nldac[i] < 32) begin
                    lfirst[i][nldac[i]] = lf[i]; llen[i][nldac[i]] = ll[i]; nldac[i]++;
                end
                if (done_a[i] && ndone[i] < 32) begin dcyc[i][ndone[i]] = ncyc; ndone[i]++; end
                pcs[i] = cs_a[i]; psclk[i] = sclk_a[i]; pldac[i] = ldac_a[i];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Raise a one-cycle start at the current negedge; k is the accepting edge.
    task automatic pulse(input int idx, input logic [15:0] d, output int k);
        if (idx == 0) begin start0 = 1'b1; data0 = d; end
        else          begin start1 = 1'b1; data1 = d; end
        k = ncyc;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_cycle(input int target);
        while (ncyc < target) @(negedge clk);
    endtask

    logic [15:0] t2_in[3]  = '{16'h0FFF, 16'h0000, 16'hF123};
    logic [15:0] t2_exp[3] = '{16'h3FFF, 16'h3000, 16'h3123};

    initial begin
        int k, k2, base, dbase, lbase, drops;
        reset = 1'b0; start0 = 1'b0; start1 = 1'b0; data0 = '0; data1 = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {30'd0, cs0, ldac0}, 32'h3);
        check("reset_idle", {28'd0, sclk0, mosi0, busy0, done0}, 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 1: default frame and timing
        base = nfrm[0]; dbase = ndone[0]; lbase = nldac[0];
        pulse(0, 16'h0ABC, k);
        check("t1_cs_low_k1", {31'd0, cs0}, 32'h0);
        check("t1_busy_k1", {31'd0, busy0}, 32'h1);
        check("t1_mosi_msb", {31'd0, mosi0}, 32'h0);
        wait_cycle(k + 139);
        check("t1_done_k139", {30'd0, done0, busy0}, 32'h3);
        @(negedge clk);
        check("t1_after_done", {30'd0, done0, busy0}, 32'h0);
        check("t1_frame", frm[0][base], 32'h3ABC);
        check("t1_bits", fbits[0][base], 32'd16);
        check("t1_cs_width", fcs[0][base], 32'd136);
        check("t1_first_rise", frise[0][base], k + 9);
        check("t1_rise_span", fspan[0][base], 32'd120);
        check("t1_ldac_first", lfirst[0][lbase], k + 137);
        check("t1_ldac_len", llen[0][lbase], 32'd2);
        check("t1_done_cyc", dcyc[0][dbase], k + 139);

        // 2: data patterns, upper nibble ignored
        for (int i = 0; i < 3; i++) begin
            base = nfrm[0];
            @(negedge clk);
            pulse(0, t2_in[i], k);
            wait_cycle(k + 141);
            check("t2_frame", frm[0][base], {16'd0, t2_exp[i]});
        end

        // 3: starts during SHIFT, last one wins
        base = nfrm[0]; dbase = ndone[0]; drops = 0;
        @(negedge clk);
        pulse(0, 16'h0100, k);
        wait_cycle(k + 20);
        pulse(0, 16'h0200, k2);
        wait_cycle(k + 30);
        pulse(0, 16'h0300, k2);
        while (ncyc < k + 278) begin
            @(negedge clk);
            if (!busy0) drops++;
        end
        check("t3_done2_now", {31'd0, done0}, 32'h1);
        wait_cycle(k + 300);
        check("t3_busy_drops", drops, 32'd0);
        check("t3_frame0", frm[0][base], 32'h3100);
        check("t3_frame1", frm[0][base + 1], 32'h3300);
        check("t3_frames", nfrm[0] - base, 32'd2);
        check("t3_dones", ndone[0] - dbase, 32'd2);
        check("t3_done1_cyc", dcyc[0][dbase], k + 139);
        check("t3_done2_cyc", dcyc[0][dbase + 1], k + 278);

        // 4: start in the DONE cycle
        base = nfrm[0]; dbase = ndone[0];
        @(negedge clk);
        pulse(0, 16'h0444, k);
        wait_cycle(k + 139);
        check("t4_in_done", {31'd0, done0}, 32'h1);
        pulse(0, 16'h0555, k2);
        check("t4_cs_setup", {30'd0, cs0, busy0}, 32'h1);
        wait_cycle(k + 290);
        check("t4_frame0", frm[0][base], 32'h3444);
        check("t4_frame1", frm[0][base + 1], 32'h3555);
        check("t4_done2_cyc", dcyc[0][dbase + 1], k + 278);
        check("t4_dones", ndone[0] - dbase, 32'd2);

        // 5: reset during the 8th bit
        @(negedge clk);
        pulse(0, 16'h0AAA, k);
        wait_cycle(k + 64);
        check("t5_inflight", {31'd0, cs0}, 32'h0);
        base = nfrm[0]; dbase = ndone[0]; lbase = nldac[0];
        reset = 1'b0;
        #1;
        check("t5_abort", {29'd0, cs0, sclk0, ldac0}, 32'h5);
        check("t5_abort_idle", {29'd0, mosi0, busy0, done0}, 32'h0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (200) @(negedge clk);
        check("t5_no_frame", nfrm[0] - base, 32'd0);
        check("t5_no_done", ndone[0] - dbase, 32'd0);
        check("t5_no_ldac", nldac[0] - lbase, 32'd0);
        pulse(0, 16'h0001, k);
        wait_cycle(k + 141);
        check("t5_clean_frame", frm[0][base], 32'h3001);
        check("t5_clean_done", dcyc[0][dbase], k + 139);

        // 6: fastest parameterisation
        base = nfrm[1]; dbase = ndone[1]; lbase = nldac[1];
        @(negedge clk);
        pulse(1, 16'h0FFF, k);
        wait_cycle(k + 36);
        check("t6_done_k36", {31'd0, done1}, 32'h1);
        wait_cycle(k + 40);
        check("t6_frame", frm[1][base], 32'h3FFF);
        check("t6_cs_width", fcs[1][base], 32'd34);
        check("t6_rise_span", fspan[1][base], 32'd30);
        check("t6_first_rise", frise[1][base], k + 3);
        check("t6_ldac_len", llen[1][lbase], 32'd1);
        check("t6_done_cyc", dcyc[1][dbase], k + 36);
        check("t6_idle", {31'd0, busy1}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
